// File: rtl/fpga_input_ctrl.sv
// fpga_input_ctrl: services IN by reading slide switches on a confirmed keypress.
// Ports: clk, rst_n, in_req, sw, key_n -> in_data, in_valid, stall, waiting.
module fpga_input_ctrl #(
  parameter int SW_WIDTH        = 18,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_req,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                key_n,
  output logic [31:0]         in_data,
  output logic                in_valid,
  output logic                stall,
  output logic                waiting
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sw_m_q, sw_m_d;
  logic [SW_WIDTH-1:0]  sw_s_q, sw_s_d;
  logic                 key_m_q, key_m_d;
  logic                 key_s_q, key_s_d;
  logic                 key_db_q, key_db_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic [31:0]          in_data_q, in_data_d;
  logic                 in_valid_q, in_valid_d;
  logic                 press_ev;
  logic                 release_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m_q     <= '0;
      sw_s_q     <= '0;
      key_m_q    <= 1'b1;
      key_s_q    <= 1'b1;
      key_db_q   <= 1'b1;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      sw_m_q     <= sw_m_d;
      sw_s_q     <= sw_s_d;
      key_m_q    <= key_m_d;
      key_s_q    <= key_s_d;
      key_db_q   <= key_db_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
    end
  end

  // Synchronizers and debounce
  always_comb begin
    sw_m_d   = sw;
    sw_s_d   = sw_m_q;
    key_m_d  = key_n;
    key_s_d  = key_m_q;
    key_db_d = key_db_q;
    cnt_d    = '0;
    if (key_s_q != key_db_q) begin
      if (cnt_q == CNT_LAST) begin
        key_db_d = key_s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Events coincide with the edge on which the debounced level flips
  assign press_ev   = key_db_q & ~key_db_d;
  assign release_ev = ~key_db_q & key_db_d;

  always_comb begin
    state_d    = state_q;
    in_data_d  = in_data_q;
    in_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_req) begin
          state_d = key_db_q ? S_WAIT_PRESS : S_ARM;
        end
      end
      S_ARM: begin
        if (!in_req) begin
          state_d = S_IDLE;
        end else if (release_ev) begin
          state_d = S_WAIT_PRESS;
        end
      end
      S_WAIT_PRESS: begin
        if (!in_req) begin
          state_d = S_IDLE;
        end else if (press_ev) begin
          in_data_d = 32'(sw_s_q);
          state_d   = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (!in_req) begin
          state_d = S_IDLE;
        end else if (release_ev) begin
          in_valid_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (!in_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from the state flop so reset clears them without a clock
  assign stall = (state_q == S_ARM) ||
                 (state_q == S_WAIT_PRESS) ||
                 (state_q == S_WAIT_RELEASE);
  assign waiting  = stall;
  assign in_data  = in_data_q;
  assign in_valid = in_valid_q;

endmodule

// File: doc/fpga_input_ctrl.md
Name: fpga_input_ctrl

Overview:
- Board-input side of the FPGA debug I/O: services the processor's IN instruction by reading the slide switches when the user confirms with a pushbutton.
- Sits between the board pins (SW, KEY) and the datapath; stalls the core while it waits for the user.
- Drives the `waiting` flag that the display block shows as "11" in place of the PC.
- Includes 2-flop synchronizers, pushbutton debounce, and a request/valid handshake FSM.

Parameters:
- SW_WIDTH, 18: number of slide switches sampled; zero-extended to 32 bits.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a key level change; minimum 1.
- CNT_WIDTH, 18: debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_req  in  1  processor is executing IN; held high until in_valid is seen.
- sw  in  SW_WIDTH  raw slide switches, asynchronous.
- key_n  in  1  raw confirm pushbutton, active-low, asynchronous, bouncy.
- in_data  out  32  value returned to the register file.
- in_valid  out  1  one-cycle pulse; in_data is valid this cycle.
- stall  out  1  freezes PC/pipeline while the request is pending.
- waiting  out  1  to display block: user input is awaited.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_data=0; in_valid=0; stall=0; waiting=0; synchronizers reset to key released (1) and sw=0; debounced key=released; debounce counter=0.
- Synchronizers: sw and key_n each pass through 2 flops. sw_s and key_s are 2 cycles behind the pins.
- Debounce:
  - If key_s equals the debounced level, counter=0.
  - Otherwise counter increments each cycle. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips on the next edge and counter=0.
  - Net effect: the level must stay stable for DEBOUNCE_CYCLES cycles.
  - press_ev: one-cycle event on the debounced 1->0 flip. release_ev: one-cycle event on the debounced 0->1 flip.
- FSM states: IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: if in_req, go to ARM if the debounced key is currently pressed, else to WAIT_PRESS.
  - ARM: wait for release_ev, then go to WAIT_PRESS. This stops a key held from a previous transfer from confirming a new one.
  - WAIT_PRESS: on press_ev, in_data <= zero-extended sw_s sampled that same cycle; go to WAIT_RELEASE.
  - WAIT_RELEASE: on release_ev, go to DONE; in_valid=1 for exactly the first DONE cycle.
  - DONE: stay while in_req=1; return to IDLE when in_req=0. No new request is accepted until in_req has been seen low.
- Outputs:
  - stall=1 and waiting=1 in ARM, WAIT_PRESS and WAIT_RELEASE; 0 in IDLE and DONE.
  - in_valid is registered and high only in the first cycle of DONE.
  - in_data holds its value until the next latch or reset.
- Abort: in_req=0 in ARM, WAIT_PRESS or WAIT_RELEASE returns to IDLE next cycle.
  - No in_valid is produced.
  - in_data keeps the value latched by the aborted transfer, if any.
- Simultaneous in_req fall and release_ev in WAIT_RELEASE: abort wins; no in_valid.
- Switch changes after the press latch do not affect in_data.
- Bounces shorter than DEBOUNCE_CYCLES produce no events.
- Reset asserted mid-transfer: immediate return to reset values; stall drops asynchronously.

Test Plan:
- Basic read (DEBOUNCE_CYCLES=4): sw=18'h0002A, raise in_req, press key 10 cycles, release.
  - stall/waiting high 1 cycle after in_req.
  - in_data=32'h0000002A latched 2+4 cycles after the press.
  - in_valid is a single pulse 2+4 cycles after the release; stall=0 in that same cycle.
- Bounce rejection: toggle key_n with 2-cycle pulses ×5, then hold low 8 cycles.
  - Exactly one latch, at the final stable press.
  - No latch during the glitches.
- Held key: key held low before in_req rises.
  - FSM enters ARM; no latch until release, then a fresh press.
  - in_data equals sw at the second press (sw changed 5→9 in between ⇒ 9).
- Abort: drop in_req during WAIT_RELEASE.
  - stall=0 next cycle; in_valid never pulses.
  - A following request completes normally.
- Sw change after press: sw 3→7 while key held.
  - in_data stays 3 and in_valid reports 3.
- Async reset mid-WAIT_PRESS: assert rst_n=0 off clock edge.
  - stall, waiting and in_data go to 0 before the next clk edge.
  - After release, in_req held high restarts from IDLE.
